// File: rtl/output_serializer.sv
// Output serializer: buffers strobed multiplexer samples in a small FIFO and
// shifts each one off-chip MSB-first on a 3-wire link (clock, data, frame sync).
// Optional build macro: OUTPUT_SERIALIZER_PARITY_EN appends an even-parity bit
// after the LSB of every frame.
module output_serializer #(
  parameter int unsigned SUM_TRUNCATION = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CLK_DIV        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SUM_TRUNCATION-1:0]     i_multiplexed_wavelet_out,
  input  logic                          i_sample_strobe,
  input  logic                          i_enable,
  output logic                          o_serial_clk,
  output logic                          o_serial_data,
  output logic                          o_frame_sync,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
  localparam int unsigned NBits = SUM_TRUNCATION + 1;
`else
  localparam int unsigned NBits = SUM_TRUNCATION;
`endif
  localparam int unsigned BitW = (NBits > 1) ? $clog2(NBits) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(NBits - 1);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  // Registers
  state_e                    r_state;
  logic [SUM_TRUNCATION-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]           r_wr_ptr;
  logic [PtrW-1:0]           r_rd_ptr;
  logic [LvlW-1:0]           r_level;
  logic                      r_overflow;
  logic [NBits-1:0]          r_sr;
  logic [DivW-1:0]           r_div;
  logic [BitW-1:0]           r_bit;
  logic                      r_phase;  // 0: serial clock low half, 1: high half
  logic                      r_sclk;
  logic                      r_sdata;
  logic                      r_fsync;
  logic                      r_busy;

  // Next-state wires
  state_e                    w_state_d;
  logic [NBits-1:0]          w_sr_d;
  logic [DivW-1:0]           w_div_d;
  logic [BitW-1:0]           w_bit_d;
  logic                      w_phase_d;
  logic                      w_sclk_d;
  logic                      w_sdata_d;
  logic                      w_fsync_d;
  logic                      w_busy_d;
  logic [LvlW-1:0]           w_level_d;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_empty;
  logic                      w_full;
  logic [SUM_TRUNCATION-1:0] w_head;
  logic [NBits-1:0]          w_load;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LvlFull);
  assign w_head  = r_mem[r_rd_ptr];

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  assign w_load = {w_head, ^w_head};
`else
  assign w_load = w_head;
`endif

  // A pop frees a slot in the same cycle, so a strobe into a full FIFO still lands.
  assign w_push = i_sample_strobe && (!w_full || w_pop);

  // Occupancy update from the push/pop pair
  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase
  end

  // Framing FSM: next state, shift register and registered pin values
  always_comb begin
    w_state_d = r_state;
    w_sr_d    = r_sr;
    w_div_d   = r_div;
    w_bit_d   = r_bit;
    w_phase_d = r_phase;
    w_sclk_d  = r_sclk;
    w_sdata_d = r_sdata;
    w_fsync_d = r_fsync;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable && !w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StShift;
          w_sr_d    = w_load;
          w_div_d   = '0;
          w_bit_d   = '0;
          w_phase_d = 1'b0;
          w_sclk_d  = 1'b0;
          w_sdata_d = w_load[NBits-1];
          w_fsync_d = 1'b1;
        end
      end
      StShift: begin
        if (r_div == DivLast) begin
          w_div_d = '0;
          if (!r_phase) begin
            w_phase_d = 1'b1;
            w_sclk_d  = 1'b1;
          end else if (r_bit == BitLast) begin
            w_state_d = StGap;
            w_phase_d = 1'b0;
            w_sclk_d  = 1'b0;
            w_sdata_d = 1'b0;
            w_fsync_d = 1'b0;
          end else begin
            // Data only moves on the falling edge of the serial clock
            w_bit_d   = r_bit + 1'b1;
            w_phase_d = 1'b0;
            w_sclk_d  = 1'b0;
            w_sr_d    = r_sr << 1;
            w_sdata_d = r_sr[NBits-2];
          end
        end else begin
          w_div_d = r_div + 1'b1;
        end
      end
      StGap: begin
        if (r_div == DivLast) begin
          w_div_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_div_d = r_div + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_multiplexed_wavelet_out;
    end
  end

  // State, pointers and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_sr       <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_phase    <= 1'b0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_fsync    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sr    <= w_sr_d;
      r_div   <= w_div_d;
      r_bit   <= w_bit_d;
      r_phase <= w_phase_d;
      r_sclk  <= w_sclk_d;
      r_sdata <= w_sdata_d;
      r_fsync <= w_fsync_d;
      r_busy  <= w_busy_d;
      r_level <= w_level_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_sample_strobe && !w_push) r_overflow <= 1'b1;
    end
  end

  assign o_serial_clk  = r_sclk;
  assign o_serial_data = r_sdata;
  assign o_frame_sync  = r_fsync;
  assign o_busy        = r_busy;
  assign o_fifo_level  = r_level;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: directed scenarios plus random
// traffic, compared each cycle against a queue-and-timer reference model, with
// an independent pin-level receiver checking the decoded frames.
module tb_output_serializer;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CD    = 2;
`ifdef OUTPUT_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int SHIFT_LEN = 2 * CD * NB;
  localparam int FRAME_LEN = SHIFT_LEN + CD;

  logic         clk;
  logic         rst;
  logic [W-1:0] i_data;
  logic         i_strobe;
  logic         i_en;
  logic         o_sclk;
  logic         o_sdata;
  logic         o_fsync;
  logic         o_busy;
  logic [2:0]   o_level;
  logic         o_ovf;

  output_serializer #(
    .SUM_TRUNCATION(W),
    .FIFO_DEPTH    (DEPTH),
    .CLK_DIV       (CD)
  ) u_dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_multiplexed_wavelet_out(i_data),
    .i_sample_strobe          (i_strobe),
    .i_enable                 (i_en),
    .o_serial_clk             (o_sclk),
    .o_serial_data            (o_sdata),
    .o_frame_sync             (o_fsync),
    .o_busy                   (o_busy),
    .o_fifo_level             (o_level),
    .o_overflow               (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0]  mq[$];
  logic [NB-1:0] exp_frames[$];
  logic [NB-1:0] cur_frame;
  int            busy_left;
  logic          m_ovf;

  // Receiver state
  logic [NB-1:0] rx;
  int            rx_n;
  logic          prev_sclk;
  logic          prev_fsync;
  int            fs_cnt;
  int            rise_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] make_frame(input logic [W-1:0] s);
`ifdef OUTPUT_SERIALIZER_PARITY_EN
    return {s, ^s};
`else
    return s;
`endif
  endfunction

  task automatic model_step(input logic stb, input logic [W-1:0] d, input logic en,
                            input logic r);
    logic pop;
    logic acc;
    if (r) begin
      mq.delete();
      exp_frames.delete();
      busy_left = 0;
      m_ovf     = 1'b0;
    end else begin
      pop = (busy_left == 0) && en && (mq.size() > 0);
      acc = stb && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        cur_frame = make_frame(mq.pop_front());
        exp_frames.push_back(cur_frame);
        busy_left = FRAME_LEN;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (acc) mq.push_back(d);
      else if (stb) m_ovf = 1'b1;
    end
  endtask

  // Expected pins packed as {level, ovf, busy, fsync, sclk, sdata}
  function automatic logic [7:0] model_pins();
    int   t;
    logic fs;
    logic sc;
    logic sd;
    fs = 1'b0;
    sc = 1'b0;
    sd = 1'b0;
    if (busy_left > 0) begin
      t = FRAME_LEN - busy_left;
      if (t < SHIFT_LEN) begin
        fs = 1'b1;
        sc = (t % (2 * CD)) >= CD;
        sd = cur_frame[NB - 1 - t / (2 * CD)];
      end
    end
    return {3'(mq.size()), m_ovf, busy_left > 0, fs, sc, sd};
  endfunction

  task automatic tick(input logic stb, input logic [W-1:0] d, input logic en, input logic r);
    logic [NB-1:0] want;
    rst      = r;
    i_strobe = stb;
    i_data   = d;
    i_en     = en;
    @(posedge clk);
    model_step(stb, d, en, r);
    @(negedge clk);
    check_eq("cycle pins", {24'd0, o_level, o_ovf, o_busy, o_fsync, o_sclk, o_sdata},
             {24'd0, model_pins()});
    if (o_fsync) fs_cnt++;
    if (r) begin
      rx_n = 0;
    end else begin
      if (!prev_fsync && o_fsync) rx_n = 0;
      if (!prev_sclk && o_sclk) begin
        rx = {rx[NB-2:0], o_sdata};
        rx_n++;
        rise_cnt++;
      end
      if (prev_fsync && !o_fsync) begin
        check_eq("rx bit count", rx_n, NB);
        if (exp_frames.size() == 0) begin
          check_eq("rx unexpected frame", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          want = exp_frames.pop_front();
          check_eq("rx frame", 32'(rx), 32'(want));
        end
      end
    end
    prev_sclk  = o_sclk;
    prev_fsync = o_fsync;
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) tick(1'b0, '0, en, 1'b0);
  endtask

  initial begin
    busy_left  = 0;
    m_ovf      = 1'b0;
    cur_frame  = '0;
    rx         = '0;
    rx_n       = 0;
    prev_sclk  = 1'b0;
    prev_fsync = 1'b0;
    fs_cnt     = 0;
    rise_cnt   = 0;
    rst        = 1'b1;
    i_strobe   = 1'b0;
    i_data     = '0;
    i_en       = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);
    check_eq("reset level", 32'(o_level), 0);
    check_eq("reset busy", 32'(o_busy), 0);
    check_eq("reset pins", {28'd0, o_sclk, o_sdata, o_fsync, o_ovf}, 0);

    // Single frame of 8'hA5
    fs_cnt = 0;
    tick(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(FRAME_LEN + 6, 1'b1);
    check_eq("A5 frame_sync cycles", fs_cnt, SHIFT_LEN);
    check_eq("A5 busy after", 32'(o_busy), 0);

    // Simultaneous push and pop with full FIFO
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
    check_eq("fill level", 32'(o_level), 4);
    tick(1'b1, 8'hFF, 1'b1, 1'b0);
    check_eq("push+pop level", 32'(o_level), 4);
    check_eq("push+pop no overflow", 32'(o_ovf), 0);
    idle(5 * (FRAME_LEN + 1) + 4, 1'b1);
    check_eq("drain level", 32'(o_level), 0);

    // Overflow with enable low, then back-to-back drain
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
    check_eq("overflow level", 32'(o_level), 4);
    check_eq("overflow flag", 32'(o_ovf), 1);
    idle(4 * (FRAME_LEN + 1) + 4, 1'b1);
    check_eq("overflow sticky", 32'(o_ovf), 1);

    // Reset mid-frame during bit 3 of 8'h3C
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 8'h3C, 1'b1, 1'b0);
    tick(1'b1, 8'h11, 1'b1, 1'b0);
    tick(1'b1, 8'h22, 1'b1, 1'b0);
    idle(3 * 2 * CD - 2 + 1, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b1);
    check_eq("abort sclk", 32'(o_sclk), 0);
    check_eq("abort fsync", 32'(o_fsync), 0);
    check_eq("abort level", 32'(o_level), 0);
    rise_cnt = 0;
    idle(20, 1'b1);
    check_eq("abort no edges", rise_cnt, 0);

    // Random traffic with varying strobe density, enable gaps and rare resets
    for (int i = 0; i < 3000; i++) begin
      logic stb;
      logic en;
      logic r;
      int   dens;
      dens = (i / 500) % 2 == 0 ? 3 : 40;
      stb  = ($urandom_range(0, dens) == 0);
      en   = ((i / 200) % 4) != 3;
      r    = ($urandom_range(0, 999) == 0);
      tick(stb, W'($urandom), en, r);
    end
    idle(6 * (FRAME_LEN + 1), 1'b1);
    check_eq("final level", 32'(o_level), 0);
    check_eq("final busy", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
